// File: rtl/syscall_unit_pkg.sv
// Shared constants for the syscall service unit: service codes, console item
// kinds and the control FSM state encoding.
package syscall_pkg;

  localparam int SYS_PRINT_INT  = 1;
  localparam int SYS_PRINT_STR  = 4;
  localparam int SYS_EXIT       = 10;
  localparam int SYS_PRINT_CHAR = 11;

  localparam logic OUT_CHAR = 1'b0;
  localparam logic OUT_INT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    STR_REQ,
    STR_WAIT,
    HALTED
  } state_t;

endpackage

// File: rtl/syscall_unit_if.sv
// Console output stream of the syscall unit: one item per valid/ready handshake.
interface syscall_unit_if #(
  parameter int DATA_W = 32
) ();

  logic              out_valid;
  logic              out_kind;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (output out_valid, output out_kind, output out_data, input out_ready);
  modport slave  (input out_valid, input out_kind, input out_data, output out_ready);

endinterface

// File: rtl/syscall_str_walker.sv
// String walker: holds the string base and byte index, issues the byte read
// request, flags a NUL terminator and reports when the length cap is reached.
module syscall_str_walker
  import syscall_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MAX_STR_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_in,
  input  logic              req,
  input  logic              advance,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              byte_nul,
  output logic              last
);

  // One extra bit so idx+1 can equal MAX_STR_LEN without overflowing.
  localparam int IDX_W = $clog2(MAX_STR_LEN) + 1;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_nx;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nx;

  always_comb begin
    base_nx = base;
    idx_nx  = idx;
    if (start) begin
      base_nx = base_in;
      idx_nx  = '0;
    end else if (advance) begin
      idx_nx = idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    base <= base_nx;
  end

  // The address is formed from the next-cycle base/idx so the request can be
  // issued on the same edge that starts or advances the walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      idx       <= idx_nx;
      mem_rd_en <= req;
      if (req) begin
        mem_addr <= base_nx + ADDR_W'(idx_nx);
      end
    end
  end

  assign byte_nul = (mem_rd_data == 8'h00);
  assign last     = ((idx + IDX_W'(1)) == IDX_W'(MAX_STR_LEN));

endmodule

// File: rtl/syscall_unit.sv
// Syscall service unit: decodes v0, runs print-int/char/string and exit as a
// multi-cycle service, stalling the pipeline and streaming console items.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_STR_LEN = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                syscall_valid,
  input  logic [DATA_W-1:0]   v0,
  input  logic [DATA_W-1:0]   a0,
  output logic                stall,
  output logic                halted,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rd_data,
  syscall_unit_if.master      cons,
  output logic                err_code,
  output logic                str_trunc
);

  state_t            state;
  logic              in_str;
  logic              out_valid;
  logic              out_kind;
  logic [DATA_W-1:0] out_data;

  logic is_int;
  logic is_chr;
  logic is_str;
  logic is_exit;
  logic known;
  logic emit_hs;
  logic str_start;
  logic str_req;
  logic str_adv;
  logic byte_nul;
  logic last;

  assign is_int  = (v0 == DATA_W'(SYS_PRINT_INT));
  assign is_chr  = (v0 == DATA_W'(SYS_PRINT_CHAR));
  assign is_str  = (v0 == DATA_W'(SYS_PRINT_STR));
  assign is_exit = (v0 == DATA_W'(SYS_EXIT));
  assign known   = is_int | is_chr | is_str | is_exit;

  assign stall = (state != IDLE) || (syscall_valid && known);

  assign emit_hs   = (state == EMIT) && cons.out_ready;
  assign str_start = (state == IDLE) && syscall_valid && is_str;
  assign str_adv   = emit_hs && in_str;
  assign str_req   = str_start || (str_adv && !last);

  syscall_str_walker #(
    .ADDR_W      (ADDR_W),
    .MAX_STR_LEN (MAX_STR_LEN)
  ) u_walker (
    .clk         (clk),
    .rst         (rst),
    .start       (str_start),
    .base_in     (ADDR_W'(a0)),
    .req         (str_req),
    .advance     (str_adv),
    .mem_rd_data (mem_rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .byte_nul    (byte_nul),
    .last        (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_str    <= 1'b0;
      halted    <= 1'b0;
      out_valid <= 1'b0;
      out_kind  <= OUT_CHAR;
      out_data  <= '0;
      err_code  <= 1'b0;
      str_trunc <= 1'b0;
    end else begin
      err_code  <= 1'b0;
      str_trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (syscall_valid) begin
            if (is_int) begin
              out_data  <= a0;
              out_kind  <= OUT_INT;
              out_valid <= 1'b1;
              in_str    <= 1'b0;
              state     <= EMIT;
            end else if (is_chr) begin
              out_data  <= DATA_W'(a0[7:0]);
              out_kind  <= OUT_CHAR;
              out_valid <= 1'b1;
              in_str    <= 1'b0;
              state     <= EMIT;
            end else if (is_str) begin
              in_str <= 1'b1;
              state  <= STR_REQ;
            end else if (is_exit) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              err_code <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (cons.out_ready) begin
            out_valid <= 1'b0;
            if (in_str && !last) begin
              state <= STR_REQ;
            end else begin
              str_trunc <= in_str;
              in_str    <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        STR_REQ: begin
          state <= STR_WAIT;
        end
        STR_WAIT: begin
          if (byte_nul) begin
            in_str <= 1'b0;
            state  <= IDLE;
          end else begin
            out_data  <= DATA_W'(mem_rd_data);
            out_kind  <= OUT_CHAR;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cons.out_valid = out_valid;
  assign cons.out_kind  = out_kind;
  assign cons.out_data  = out_data;

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: a reference model queues expected console
// items and read addresses; a monitor compares them as the DUT produces them.
module tb_syscall_unit;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int MAX_STR_LEN = 4;

  typedef struct {
    logic        kind;
    logic [31:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_valid;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        halted;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        err_code;
  logic        str_trunc;

  syscall_unit_if #(.DATA_W(DATA_W)) cons ();

  syscall_unit #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MAX_STR_LEN (MAX_STR_LEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .syscall_valid (syscall_valid),
    .v0            (v0),
    .a0            (a0),
    .stall         (stall),
    .halted        (halted),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rd_data   (mem_rd_data),
    .cons          (cons),
    .err_code      (err_code),
    .str_trunc     (str_trunc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[9:0]];
  end

  item_t       exp_q[$];
  logic [31:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int trunc_seen = 0;
  int valid_seen = 0;
  int exp_err = 0;
  int exp_trunc = 0;
  int ready_mode = 0;
  int ready_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  function automatic bit is_known(input logic [31:0] code);
    return (code == 32'd1) || (code == 32'd4) || (code == 32'd10) || (code == 32'd11);
  endfunction

  // Console sink: ready is either held high, randomized, or forced low for a count.
  initial begin
    cons.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_hold > 0) begin
        cons.out_ready = 1'b0;
        ready_hold--;
      end else begin
        cons.out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    logic        pv;
    logic        pr;
    logic        pk;
    logic [31:0] pd;
    item_t       e;
    pv = 1'b0;
    pr = 1'b0;
    pk = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (err_code) err_seen++;
        if (str_trunc) trunc_seen++;
        if (mem_rd_en) begin
          if (addr_q.size() == 0) fail("unexp_rd", $sformatf("read at %0h", mem_addr));
          else check("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
        if (pv && !pr)
          check("hold", {cons.out_valid, cons.out_kind, cons.out_data}, {1'b1, pk, pd});
        if (cons.out_valid) valid_seen++;
        if (cons.out_valid && cons.out_ready) begin
          if (exp_q.size() == 0) begin
            fail("unexp_item", $sformatf("kind %0d data %0h", cons.out_kind, cons.out_data));
          end else begin
            e = exp_q.pop_front();
            check("item", {cons.out_kind, cons.out_data}, {e.kind, e.data});
          end
        end
        pv = cons.out_valid;
        pr = cons.out_ready;
        pk = cons.out_kind;
        pd = cons.out_data;
      end
    end
  end

  // Reference model: expected items, read addresses and stall length from the service rules.
  task automatic model(input logic [31:0] code, input logic [31:0] arg, input bit rdy_high,
                       output int st);
    item_t       it;
    int          n;
    logic [31:0] a;
    logic [7:0]  b;
    st = -1;
    case (code)
      32'd1: begin
        it.kind = 1'b1; it.data = arg; exp_q.push_back(it); st = 2;
      end
      32'd11: begin
        it.kind = 1'b0; it.data = {24'h0, arg[7:0]}; exp_q.push_back(it); st = 2;
      end
      32'd4: begin
        n = 0;
        for (int i = 0; i < MAX_STR_LEN; i++) begin
          a = arg + 32'(i);
          addr_q.push_back(a);
          b = mem[a[9:0]];
          if (b == 8'h00) break;
          it.kind = 1'b0; it.data = {24'h0, b}; exp_q.push_back(it);
          n++;
        end
        if (n == MAX_STR_LEN) begin
          exp_trunc++;
          st = 1 + 3 * MAX_STR_LEN;
        end else begin
          st = 1 + 3 * n + 2;
        end
      end
      default: begin
        exp_err++; st = 0;
      end
    endcase
    if (!rdy_high && st > 0) st = -1;
  endtask

  task automatic run_syscall(input logic [31:0] code, input logic [31:0] arg,
                             input int exp_stall, input int hold);
    int cnt;
    int guard;
    @(negedge clk);
    syscall_valid = 1'b1;
    v0 = code;
    a0 = arg;
    ready_hold = hold;
    #1;
    check("stall_accept", 64'(stall), 64'(is_known(code)));
    cnt = is_known(code) ? 1 : 0;
    guard = 0;
    @(negedge clk);
    syscall_valid = 1'b0;
    while (stall && guard < 500) begin
      cnt++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 500) fail("stall_timeout", "stall never dropped");
    if (exp_stall >= 0) check("stall_cycles", 64'(cnt), 64'(exp_stall));
    repeat (2) @(negedge clk);
    check("err_cnt", 64'(err_seen), 64'(exp_err));
    check("trunc_cnt", 64'(trunc_seen), 64'(exp_trunc));
    check("queues_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
  endtask

  task automatic do_svc(input logic [31:0] code, input logic [31:0] arg);
    int st;
    model(code, arg, ready_mode == 0, st);
    run_syscall(code, arg, st, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          st;
    int          vs;
    int          sel;
    logic [31:0] code;
    logic [31:0] arg;

    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));

    rst = 1'b1;
    syscall_valid = 1'b0;
    v0 = '0;
    a0 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs",
          {stall, halted, mem_rd_en, mem_addr, cons.out_valid, cons.out_kind, cons.out_data,
           err_code, str_trunc}, '0);

    // print integer
    do_svc(32'd1, 32'hFFFF_FFF9);

    // "Hi" at 0x100
    mem[10'h100] = 8'h48;
    mem[10'h101] = 8'h69;
    mem[10'h102] = 8'h00;
    model(32'd4, 32'h100, 1'b1, st);
    check("hi_model_stall", 64'(st), 64'd9);
    run_syscall(32'd4, 32'h100, st, 0);

    // print char with the console back-pressured for 3 cycles
    model(32'd11, 32'h1234_5641, 1'b1, st);
    run_syscall(32'd11, 32'h1234_5641, 5, 3);

    // no terminator within the cap: truncation
    for (int i = 0; i < 6; i++) mem[10'h200 + i] = 8'h61 + 8'(i);
    do_svc(32'd4, 32'h200);

    // string wrapping past the top of the address space
    mem[10'h3FF] = 8'h5A;
    mem[10'h000] = 8'h00;
    do_svc(32'd4, 32'hFFFF_FFFF);

    // unknown code
    do_svc(32'd7, 32'h0);

    for (int t = 0; t < 40; t++) begin
      ready_mode = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      arg = $urandom;
      if (sel <= 2) code = 32'd1;
      else if (sel <= 4) code = 32'd11;
      else if (sel <= 8) code = 32'd4;
      else begin
        code = $urandom;
        if (is_known(code)) code = 32'd2;
      end
      do_svc(code, arg);
    end
    ready_mode = 0;

    // reset while the first string byte is being read: byte must be dropped
    mem[10'h300] = 8'h41;
    addr_q.push_back(32'h300);
    @(negedge clk);
    syscall_valid = 1'b1;
    v0 = 32'd4;
    a0 = 32'h300;
    @(negedge clk);
    syscall_valid = 1'b0;
    check("midrst_req", 64'(mem_rd_en), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    vs = valid_seen;
    @(negedge clk);
    check("midrst_outputs",
          {stall, halted, mem_rd_en, mem_addr, cons.out_valid, cons.out_kind, cons.out_data,
           err_code, str_trunc}, '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_item", 64'(valid_seen), 64'(vs));
    check("midrst_queues", 64'(exp_q.size() + addr_q.size()), 64'd0);

    // exit, then an ignored syscall, then reset
    @(negedge clk);
    syscall_valid = 1'b1;
    v0 = 32'd10;
    a0 = 32'h0;
    #1;
    check("exit_stall", 64'(stall), 64'd1);
    check("exit_not_yet_halted", 64'(halted), 64'd0);
    @(negedge clk);
    syscall_valid = 1'b0;
    check("halted_rise", {halted, stall}, 2'b11);
    vs = valid_seen;
    syscall_valid = 1'b1;
    v0 = 32'd1;
    a0 = 32'hDEAD_BEEF;
    @(negedge clk);
    syscall_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("halted_ignores", 64'(valid_seen), 64'(vs));
    check("halted_sticky", {halted, stall}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("halt_cleared", {halted, stall}, 2'b00);

    // service still works after reset
    do_svc(32'd11, 32'h0000_0037);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Clocked, parametrised syscall service unit for the MIPS core. It decodes `$v0` on a syscall from the execute stage and performs the service as a multi-cycle operation: print integer, print character, print NUL-terminated string (walked byte-by-byte from data memory), or exit. While a service is in flight it stalls the pipeline. Console output goes over a valid/ready stream, and a sticky halt flag replaces the old simulation-only kill.

## Interface
- `DATA_W`, 32: width of `v0`, `a0` and `out_data`.
- `ADDR_W`, 32: byte-address width of the string read port.
- `MAX_STR_LEN`, 256: maximum bytes emitted per print-string before truncation; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `syscall_valid`  in  1  syscall instruction present this cycle.
- `v0`  in  DATA_W  service code.
- `a0`  in  DATA_W  argument (value, char, or string base address).
- `stall`  out  1  hold pipeline; combinational.
- `halted`  out  1  exit taken; sticky until `rst`.
- `mem_rd_en`  out  1  byte read request.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_rd_data`  in  8  read byte, valid exactly 1 cycle after `mem_rd_en`.
- `out_valid`  out  1  console item available.
- `out_kind`  out  1  0 = char, 1 = integer.
- `out_data`  out  DATA_W  item; chars zero-extended.
- `out_ready`  in  1  console accepts the item.
- `err_code`  out  1  one-cycle pulse: unknown code.
- `str_trunc`  out  1  one-cycle pulse: string hit MAX_STR_LEN.

## Operation
- States: IDLE, EMIT, STR_REQ, STR_WAIT, HALTED.
- All outputs reset to 0. State resets to IDLE and the string index to 0.
- IDLE, `syscall_valid`:
  - code 1: latch `a0`, kind=1, go to EMIT.
  - code 11: latch `{0,a0[7:0]}`, kind=0, go to EMIT.
  - code 4: latch base=`a0[ADDR_W-1:0]`, idx=0, go to STR_REQ.
  - code 10: go to HALTED.
  - any other code: pulse `err_code` next cycle, stay IDLE, no stall.
- EMIT: `out_valid`=1 with stable kind/data until `out_ready`. On the handshake cycle:
  - return to IDLE after an int/char service;
  - during a string, increment idx. If idx+1==MAX_STR_LEN, pulse `str_trunc` and go to IDLE; otherwise go to STR_REQ.
- STR_REQ: `mem_rd_en`=1, `mem_addr`=base+idx (mod 2^ADDR_W, wraps silently), go to STR_WAIT.
- STR_WAIT: sample `mem_rd_data`.
  - 0x00: go to IDLE and emit nothing.
  - otherwise: latch the byte as a char and go to EMIT.
- HALTED: absorbing. `halted`=1 and `stall`=1. `syscall_valid` is ignored.
- `stall` = (state≠IDLE) OR (IDLE AND `syscall_valid` AND code∈{1,4,10,11}).
- Reset during any state aborts the service: a pending item is dropped and `halted` clears.

## Timing
- The syscall is accepted on the clock edge where IDLE and `syscall_valid` are both true. `stall` is high in that same cycle.
- Int/char: `out_valid` rises 1 cycle after acceptance. With `out_ready` held high, the service takes 2 cycles of stall total.
- String of N non-NUL bytes (N<MAX_STR_LEN), `out_ready` held high: 3 cycles per byte (REQ, WAIT, EMIT), plus 2 for the terminator. Total stall = 1 + 3N + 2 cycles.
- `halted` rises 1 cycle after code 10 is accepted.
- Back-to-back syscalls: a new syscall is accepted only in IDLE. The pipeline holds the instruction while `stall` is high.
- `out_data` and `out_kind` are registered and must not change while `out_valid`=1 and `out_ready`=0.

## Structure
- `syscall_pkg` holds the code constants (`SYS_PRINT_INT`=1, `SYS_PRINT_STR`=4, `SYS_EXIT`=10, `SYS_PRINT_CHAR`=11), the `OUT_CHAR`/`OUT_INT` kinds, and the state enum.
- One sub-module: `syscall_str_walker`, which owns base/idx, the read request, the NUL check and the truncation counter. The top-level FSM owns dispatch, EMIT and HALTED.

## Test plan
- v0=1, a0=0xFFFFFFF9, `out_ready`=1: one item, kind=1, data=0xFFFFFFF9; `stall` high for exactly 2 cycles.
- v0=4, a0=0x100, memory "Hi\0", `out_ready`=1: chars 0x48 then 0x69; `mem_addr` takes 0x100, 0x101, 0x102; `stall` high for 9 cycles.
- v0=11, a0=0x1234_5641, `out_ready` low for 3 cycles: `out_valid` held with data=0x41 stable; accepted on the 4th cycle.
- v0=4, MAX_STR_LEN=4, no NUL in memory: exactly 4 chars, then a `str_trunc` pulse, then IDLE.
- v0=10: `halted`=1 from the next cycle. A subsequent v0=1 syscall is ignored (no `out_valid`). `rst`=1 clears `halted` and `stall`.
- v0=7: `err_code` pulses once, `stall` stays 0. Separately, assert `rst` mid-string in STR_WAIT: all outputs are 0 on the next cycle and the dropped char is never emitted.
